// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the encoder and decoder: widths, codeword bit map,
// syndrome-to-bit table and the pipeline stage payloads.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D1_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int D2_IDX = 4;
    localparam int D3_IDX = 5;
    localparam int D4_IDX = 6;

    // Indexed by syndrome {s2,s1,s0}; each entry marks the codeword bit to invert.
    localparam logic [CODE_W-1:0] SYN_FLIP [0:7] = '{
        7'b0000000,
        7'b0000001,
        7'b0000010,
        7'b0000100,
        7'b0001000,
        7'b0010000,
        7'b0100000,
        7'b1000000
    };

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [SYN_W-1:0]  syn;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
        logic [SYN_W-1:0]  syn;
    } s2_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        return {c[D1_IDX], c[D2_IDX], c[D3_IDX], c[D4_IDX]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Hamming(7,4) syndrome generator; purely combinational, zero latency.
// No flow control: output follows the code input.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn
);

    assign syn[0] = code[P1_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D4_IDX];
    assign syn[1] = code[P2_IDX] ^ code[D1_IDX] ^ code[D3_IDX] ^ code[D4_IDX];
    assign syn[2] = code[P4_IDX] ^ code[D2_IDX] ^ code[D3_IDX] ^ code[D4_IDX];

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(7,4) single-error-correcting decoder with corrected-word counter; latency 2 cycles.
// Valid/ready backpressure: output holds while out_ready=0, S1 fills, then in_ready drops.
module hamming_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [SYN_W-1:0]  out_syn,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic              s1_valid;
    logic              s2_valid;
    logic              en1;
    logic              en2;
    logic [SYN_W-1:0]  in_syn;
    logic [CODE_W-1:0] fixed_code;
    logic              out_xfer;
    s1_t               s1_q;
    s2_t               s2_d;
    s2_t               s2_q;

    hamming_syndrome u_syndrome (
        .code (in_code),
        .syn  (in_syn)
    );

    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    assign fixed_code = s1_q.code ^ SYN_FLIP[s1_q.syn];
    assign s2_d.data  = extract_data(fixed_code);
    assign s2_d.err   = |s1_q.syn;
    assign s2_d.syn   = s1_q.syn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            // Valid bits always follow the upstream stage when enabled; payload only loads on a real word.
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q.code <= in_code;
                    s1_q.syn  <= in_syn;
                end
            end
            if (en2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_q.data;
    assign out_err   = s2_q.err;
    assign out_syn   = s2_q.syn;

    assign out_xfer = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (out_xfer && s2_q.err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
